dpram_copy_dma: RTL and testbench

Block-copy engine that acts as the initiator on both ports of the team's 1024×16 true dual-port RAM. It reads source words through port A and writes them to the destination through port B, one word per cycle once the pipeline has filled. It sits beside the CPU datapath and is driven by a start/len/src/dst command. It reports completion with a done pulse and rejects overlapping ranges with an err pulse.

---
 rtl/dpram_pkg.sv | 28 ++
 rtl/dpram_copy_dma_if.sv | 24 ++
 rtl/dpram_copy_dma.sv | 109 ++++++++++
 tb/tb_dpram_copy_dma.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for initiators of the 1024x16 true dual-port RAM:
// geometry, copy-engine state encoding and the range-overlap predicate.
package dpram_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Both distances wrap modulo DEPTH, so ranges straddling the top of memory are caught.
    function automatic logic ranges_overlap(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] dst,
        input logic [ADDR_W-1:0] len
    );
        logic [ADDR_W-1:0] d_fwd;
        logic [ADDR_W-1:0] d_bwd;
        d_fwd = dst - src;
        d_bwd = src - dst;
        return (d_fwd < len) || (d_bwd < len);
    endfunction

endpackage

// File: rtl/dpram_copy_dma_if.sv
// RAM-side bus of the copy engine: port A (read) and port B (write) of the dual-port RAM.
interface dpram_copy_dma_if;
    import dpram_pkg::*;

    logic [ADDR_W-1:0] addr_A;
    logic              en_A;
    logic [DATA_W-1:0] data_A;
    logic [DATA_W-1:0] out_A;
    logic [ADDR_W-1:0] addr_B;
    logic              en_B;
    logic [DATA_W-1:0] data_B;
    logic [DATA_W-1:0] out_B;

    modport master (
        output addr_A, en_A, data_A, addr_B, en_B, data_B,
        input  out_A, out_B
    );

    modport slave (
        input  addr_A, en_A, data_A, addr_B, en_B, data_B,
        output out_A, out_B
    );

endinterface

// File: rtl/dpram_copy_dma.sv
// Block-copy engine: streams words from src via RAM port A to dst via port B,
// one word per cycle, with done/err pulses for completion and overlap rejection.
module dpram_copy_dma
    import dpram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err,
    dpram_copy_dma_if.master  ram
);

    state_e            state_q;
    logic [ADDR_W-1:0] rd_cnt_q;
    logic [ADDR_W-1:0] rd_cnt_d;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic              en_b_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              unused_out_b;

    assign rd_cnt_d = rd_cnt_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            last_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            en_b_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    en_b_q <= 1'b0;
                    if (start) begin
                        if (len == '0) begin
                            done_q <= 1'b1;
                        end else if (ranges_overlap(src, dst, len)) begin
                            err_q <= 1'b1;
                        end else begin
                            src_q    <= src;
                            dst_q    <= dst;
                            last_q   <= len - ADDR_W'(1);
                            rd_cnt_q <= '0;
                            addr_a_q <= src;
                            busy_q   <= 1'b1;
                            state_q  <= COPY;
                        end
                    end
                end
                COPY: begin
                    // Word rd_cnt_q is on the read port now; its data arrives next
                    // cycle, exactly when this write address is presented.
                    en_b_q   <= 1'b1;
                    addr_b_q <= dst_q + rd_cnt_q;
                    if (rd_cnt_q == last_q) begin
                        state_q <= FLUSH;
                    end else begin
                        rd_cnt_q <= rd_cnt_d;
                        addr_a_q <= src_q + rd_cnt_d;
                    end
                end
                FLUSH: begin
                    en_b_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    en_b_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram.addr_A = addr_a_q;
    assign ram.en_A   = 1'b0;
    assign ram.data_A = '0;
    assign ram.addr_B = addr_b_q;
    assign ram.en_B   = en_b_q;
    assign ram.data_B = ram.out_A;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    assign unused_out_b = ^ram.out_B;

endmodule

// File: tb/tb_dpram_copy_dma.sv
// Randomised bench for dpram_copy_dma: a behavioural dual-port RAM plus a
// word-array reference model that applies each accepted copy as a whole.
module tb_dpram_copy_dma;
    import dpram_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src = '0;
    logic [ADDR_W-1:0] dst = '0;
    logic [ADDR_W-1:0] len = '0;
    logic              busy;
    logic              done;
    logic              err;

    dpram_copy_dma_if ram_if ();

    dpram_copy_dma dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .ram   (ram_if.master)
    );

    always #5 clk = ~clk;

    // Memory model with registered reads and a backdoor write port for preloading
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              bd_we   = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;

    always @(posedge clk) begin
        ram_if.out_A <= mem[ram_if.addr_A];
        ram_if.out_B <= mem[ram_if.addr_B];
        if (ram_if.en_A) mem[ram_if.addr_A] <= ram_if.data_A;
        if (ram_if.en_B) mem[ram_if.addr_B] <= ram_if.data_B;
        if (bd_we)       mem[bd_addr]       <= bd_data;
    end

    int vectors     = 0;
    int miscompares = 0;

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic poke(input int a, input logic [DATA_W-1:0] v);
        bd_we   = 1'b1;
        bd_addr = ADDR_W'(a);
        bd_data = v;
        ref_mem[a % DEPTH] = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issues one command (DUT idle, called just after a clock edge) and watches it
    // to completion; returns positioned in the done cycle so the next command is back-to-back.
    task automatic issue(input int s, input int d, input int l, input bit noisy);
        int fwd, bwd, c, busy_cnt, wr;
        bit ov, seen;
        fwd = (d - s + DEPTH) % DEPTH;
        bwd = (s - d + DEPTH) % DEPTH;
        ov  = (l != 0) && (fwd < l || bwd < l);
        src = ADDR_W'(s); dst = ADDR_W'(d); len = ADDR_W'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (l == 0 || ov) begin
            vectors++;
            if ({busy, ram_if.en_B, done, err} !== {1'b0, 1'b0, (l == 0), ov}) begin
                miscompares++;
                $display("FAIL reject_pulse s=%0h d=%0h l=%0d: busy/enB/done/err=%b required %b",
                         s, d, l, {busy, ram_if.en_B, done, err}, {1'b0, 1'b0, (l == 0), ov});
            end
            @(posedge clk); #1;
            vectors++;
            if ({busy, ram_if.en_B, done, err} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reject_after s=%0h d=%0h l=%0d: busy/enB/done/err=%b required 0000",
                         s, d, l, {busy, ram_if.en_B, done, err});
            end
            $display("cmd src=%0h dst=%0h len=%0d -> %s", s, d, l, ov ? "err" : "done(len0)");
            return;
        end
        c = 1; busy_cnt = 0; wr = 0; seen = 1'b0;
        while (c <= l + 8 && !seen) begin
            if (done === 1'b1) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                vectors++;
                if (err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL err_during_copy cycle %0d: err=%b required 0", c, err);
                end
                if (c <= l) begin
                    vectors++;
                    if (ram_if.addr_A !== ADDR_W'((s + c - 1) % DEPTH)) begin
                        miscompares++;
                        $display("FAIL addr_A cycle %0d: got %0h required %0h", c, ram_if.addr_A,
                                 (s + c - 1) % DEPTH);
                    end
                end
                if (ram_if.en_B === 1'b1) begin
                    vectors++;
                    if (ram_if.addr_B !== ADDR_W'((d + wr) % DEPTH) ||
                        ram_if.data_B !== ref_mem[(s + wr) % DEPTH] || c != wr + 2) begin
                        miscompares++;
                        $display("FAIL write%0d cycle %0d: addr=%0h data=%0h required addr=%0h data=%0h cycle %0d",
                                 wr, c, ram_if.addr_B, ram_if.data_B, (d + wr) % DEPTH,
                                 ref_mem[(s + wr) % DEPTH], wr + 2);
                    end
                    wr++;
                end
                if (noisy && busy === 1'b1) begin
                    start = 1'($urandom);
                    src   = ADDR_W'($urandom);
                    dst   = ADDR_W'($urandom);
                    len   = ADDR_W'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        start = 1'b0;
        vectors++;
        if (!seen || c != l + 2 || busy_cnt != l + 1 || wr != l || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL completion s=%0h d=%0h l=%0d: done_seen=%0d latency=%0d busy_cycles=%0d writes=%0d required latency=%0d busy_cycles=%0d writes=%0d",
                     s, d, l, seen, c, busy_cnt, wr, l + 2, l + 1, l);
        end
        for (int k = 0; k < l; k++)
            ref_mem[(d + k) % DEPTH] = ref_mem[(s + k) % DEPTH];
        $display("cmd src=%0h dst=%0h len=%0d -> copied, latency %0d", s, d, l, c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) poke(i, DATA_W'($urandom));
        vectors++;
        if ({busy, done, err, ram_if.en_A, ram_if.en_B} !== 5'b0 ||
            ram_if.addr_A !== '0 || ram_if.addr_B !== '0 || ram_if.data_A !== '0) begin
            miscompares++;
            $display("FAIL reset_values: flags=%b addr_A=%0h addr_B=%0h data_A=%0h required all 0",
                     {busy, done, err, ram_if.en_A, ram_if.en_B}, ram_if.addr_A, ram_if.addr_B,
                     ram_if.data_A);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_basic();
        int n;
        for (int i = 0; i < 4; i++) poke(16'h010 + i, DATA_W'(16'hA000 + i));
        issue(16'h010, 16'h200, 4, 1'b0);
        @(posedge clk); #1;
        n = mem_diff();
        vectors++;
        if (n !== 0 || mem[16'h203] !== 16'hA003) begin
            miscompares++;
            $display("FAIL basic_mem: %0d words differ, mem[203]=%0h required 0 and a003", n, mem[16'h203]);
        end
    endtask

    task automatic test_len0();
        int n;
        issue(16'h050, 16'h060, 0, 1'b0);
        n = mem_diff();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL len0_mem: %0d words differ, required 0", n);
        end
    endtask

    task automatic test_overlap();
        int n;
        issue(16'h100, 16'h102, 4, 1'b0);
        issue(16'h3FE, 16'h000, 4, 1'b0);
        n = mem_diff();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL overlap_mem: %0d words differ, required 0", n);
        end
    endtask

    task automatic test_wrap();
        int n;
        issue(16'h3FE, 16'h100, 4, 1'b0);
        @(posedge clk); #1;
        n = mem_diff();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL wrap_mem: %0d words differ, required 0", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(16'h040, 16'h280, 9, 1'b1);
        issue(16'h2C0, 16'h0C0, 5, 1'b1);
        issue(16'h150, 16'h158, 3, 1'b0);
        @(posedge clk); #1;
        n = mem_diff();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL b2b_mem: %0d words differ, required 0", n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        src = ADDR_W'(16'h020); dst = ADDR_W'(16'h300); len = ADDR_W'(8); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, ram_if.en_B, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: busy/enB/done=%b required 000", {busy, ram_if.en_B, done});
        end
        ref_mem[16'h300] = ref_mem[16'h020];
        ref_mem[16'h301] = ref_mem[16'h021];
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n = mem_diff();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_mem: %0d words differ, required 0", n);
        end
        $display("reset mid-copy applied and released");
        issue(16'h020, 16'h300, 8, 1'b0);
        @(posedge clk); #1;
        n = mem_diff();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL after_reset_mem: %0d words differ, required 0", n);
        end
    endtask

    task automatic test_random();
        int s, d, l, n;
        for (int t = 0; t < 40; t++) begin
            s = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 24);
            if ($urandom_range(0, 3) == 0)
                d = (s + $urandom_range(0, 30) + DEPTH - 15) % DEPTH;
            else
                d = $urandom_range(0, DEPTH - 1);
            issue(s, d, l, 1'($urandom));
        end
        @(posedge clk); #1;
        n = mem_diff();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL random_mem: %0d words differ, required 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_overlap();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
